i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
Upstream audio front-end stage. Deserialises an external I2S stream (SCK/WS/SD, asynchronous to clk) into parallel signed INT16 left/right sample pairs. Presents each pair with a VALID/READY handshake to the distortion stage's parallel input. Runs entirely in the clk domain by oversampling the I2S lines.

Parameters:
WIDTH, 16, sample width in bits (signed two's complement, MSB first on the wire)

Ports:
clk  input  1  system clock; must be >= 8x SCK frequency
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
SCK  input  1  I2S bit clock, asynchronous
WS  input  1  I2S word select: 0 = left, 1 = right; asynchronous
SD  input  1  I2S serial data, asynchronous
READY  input  1  downstream accepts the pair when VALID && READY at posedge clk
OUT_L  output  WIDTH  left sample
OUT_R  output  WIDTH  right sample
VALID  output  1  OUT_L/OUT_R hold a pair not yet accepted
OVERRUN  output  1  sticky: a completed pair was dropped

Behaviour:
- Reset (rst_n low at posedge clk): OUT_L=0, OUT_R=0, VALID=0, OVERRUN=0. Synchronisers, shift register, bit counter, left holding register and ARMED flag are all cleared. Reset mid-frame discards any partial word and pair.
- SCK, WS and SD each pass through a 2-flop synchroniser. A third SCK flop provides edge detection.
- Bit event: cycle where synchronised SCK = 1 and delayed SCK = 0. Nothing updates on other cycles except the handshake.
- On each bit event, with sd/ws = synchronised values and ws_q = WS captured at the previous bit event:
  - If cnt < WIDTH: write sd into the shift register at bit WIDTH-1-cnt, then increment cnt. If cnt >= WIDTH, discard the bit (longer words are truncated to the top WIDTH bits).
  - If ws != ws_q, a word boundary is detected:
    - The bit on this edge is the LSB slot of the old word, per the I2S one-bit delay.
    - Commit the word including this edge's bit. Words shorter than WIDTH keep zeros in the unfilled LSBs.
    - Reset cnt to 0, clear the shift register, then set ws_q <= ws.
- The next bit event after a boundary carries the MSB of the new word.
- ARMED is set on the first boundary after reset. Every word committed while ARMED = 0 is discarded, so the first (partial) word is never output.
- Commit of a left word (ws_q = 0) stores it in the left holding register.
- Commit of a right word (ws_q = 1) completes a pair, provided a left word has been held since the last pair:
  - If VALID = 0, or VALID && READY in the same cycle: load OUT_L and OUT_R, and VALID = 1 on the next edge.
  - Otherwise (VALID && !READY): drop the new pair, leave the outputs unchanged, and set OVERRUN = 1 until reset.
- A right word with no held left word is discarded.
- Handshake: VALID && READY at posedge clk clears VALID, unless a new pair loads in the same cycle, in which case VALID stays 1.
- OUT_L and OUT_R are stable while VALID = 1.
- Latency: VALID rises on the 4th posedge clk after the first posedge that samples raw SCK high on the right-to-left boundary edge. That is 2 for synchronisation, 1 for edge detect/commit, and 1 for the output register.

Optional Feature:
I2S_RX_MONO_EN
- Defined: each pair is replaced by the mono average. Sign-extend both samples to WIDTH+1 bits, add, then arithmetic shift right by 1. The WIDTH-bit result drives both OUT_L and OUT_R. Handshake and timing are unchanged.
- Undefined: OUT_L and OUT_R carry independent channel samples.

Test Plan:
- Reset, then 16-bit I2S frames L=0x1234, R=0xABCD at clk=16x SCK -> first frame's partial words dropped. Afterwards OUT_L=0x1234, OUT_R=0xABCD, VALID=1. Check the exact 4-cycle latency from the boundary SCK edge.
- READY held 1, three frames (0x0001/0xFFFF, 0x7FFF/0x8000, 0x0000/0x0000) -> three VALID pulses with matching values, OVERRUN stays 0.
- READY held 0 across two complete frames -> first pair held unchanged, OVERRUN=1 after the second right-word commit. Raising READY clears VALID, and OVERRUN stays 1.
- 24-bit words L=0x123456, R=0xFEDCBA -> OUT_L=0x1234, OUT_R=0xFEDC. 8-bit words L=0x5A -> OUT_L=0x5A00.
- rst_n low for 1 cycle mid-left-word -> all outputs 0. The next pair is output only after a fresh ARMED boundary; no corrupted pair is emitted.
- With I2S_RX_MONO_EN: L=0x7FFF, R=0x7FFF -> both 0x7FFF. L=0x8000, R=0x7FFF -> both 0xFFFF. L=0x0003, R=0x0000 -> both 0x0001.

Source files
------------

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
// Deserialises an oversampled I2S stream (SCK/WS/SD, asynchronous to clk)
// into signed left/right sample pairs and presents each pair to the next
// stage with a VALID/READY handshake.
//
// Optional build macro:
//   I2S_RX_MONO_EN - when defined, each pair is replaced by the mono
//                    average (floor((L+R)/2)), driven on both OUT_L and OUT_R.
//
// Ports:
//   clk      system clock, at least 8x the SCK frequency
//   rst_n    synchronous active-low reset
//   SCK      I2S bit clock (asynchronous)
//   WS       I2S word select, 0 = left, 1 = right (asynchronous)
//   SD       I2S serial data, MSB first (asynchronous)
//   READY    downstream accepts the pair when VALID && READY at posedge clk
//   OUT_L    left sample (or mono average)
//   OUT_R    right sample (or mono average)
//   VALID    OUT_L/OUT_R hold a pair not yet accepted
//   OVERRUN  sticky flag: a completed pair was dropped
// ---------------------------------------------------------------------------
module i2s_rx #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SCK,
  input  logic             WS,
  input  logic             SD,
  input  logic             READY,
  output logic [WIDTH-1:0] OUT_L,
  output logic [WIDTH-1:0] OUT_R,
  output logic             VALID,
  output logic             OVERRUN
);

  // Counter must be able to hold WIDTH itself (the "word full" state).
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  // -------------------------------------------------------------------------
  // Input synchronisers and SCK edge-detect state
  // -------------------------------------------------------------------------
  logic sck_s1, sck_s2, sck_d;
  logic ws_s1, ws_s2;
  logic sd_s1, sd_s2;

  // -------------------------------------------------------------------------
  // Deserialiser state
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             ws_q;
  logic             armed;

  // Word handed from the deserialiser to the pairing stage.
  logic             commit_q;
  logic             commit_right;
  logic [WIDTH-1:0] commit_word;

  // -------------------------------------------------------------------------
  // Pairing state
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] left_hold;
  logic             left_held;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic             bit_evt_c;
  logic             boundary_c;
  logic             cnt_room_c;
  logic [WIDTH-1:0] word_c;
  logic             pair_c;
  logic             pair_load_c;
  logic             pair_drop_c;
  logic [WIDTH-1:0] out_l_c;
  logic [WIDTH-1:0] out_r_c;

  // Rising SCK after synchronisation marks one bit slot.
  assign bit_evt_c  = sck_s2 & ~sck_d;
  assign boundary_c = bit_evt_c & (ws_s2 != ws_q);
  assign cnt_room_c = (cnt < CNT_W'(WIDTH));

  // Shift register with the current bit merged in; bits past WIDTH are dropped.
  always_comb begin
    word_c = shreg;
    if (cnt_room_c && sd_s2) begin
      word_c = shreg | (MSB_MASK >> cnt);
    end
  end

  // A right word closes a pair only if a left word is waiting for it.
  assign pair_c      = commit_q & commit_right & left_held;
  assign pair_load_c = pair_c & (~VALID | READY);
  assign pair_drop_c = pair_c & VALID & ~READY;

`ifdef I2S_RX_MONO_EN
  // Mono average: sign-extend by one bit so the sum cannot overflow.
  logic signed [WIDTH:0] sum_c;
  always_comb begin
    sum_c   = $signed({left_hold[WIDTH-1], left_hold})
            + $signed({commit_word[WIDTH-1], commit_word});
    out_l_c = WIDTH'(sum_c >>> 1);
    out_r_c = out_l_c;
  end
`else
  always_comb begin
    out_l_c = left_hold;
    out_r_c = commit_word;
  end
`endif

  // -------------------------------------------------------------------------
  // Synchronisers: 2 flops per line, third SCK flop for edge detection
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_d  <= 1'b0;
      ws_s1  <= 1'b0;
      ws_s2  <= 1'b0;
      sd_s1  <= 1'b0;
      sd_s2  <= 1'b0;
    end else begin
      sck_s1 <= SCK;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
      ws_s1  <= WS;
      ws_s2  <= ws_s1;
      sd_s1  <= SD;
      sd_s2  <= sd_s1;
    end
  end

  // -------------------------------------------------------------------------
  // Deserialiser: collects bits MSB first; a WS change means this slot is
  // the LSB of the outgoing word (I2S one-bit delay), so the word is
  // committed including the current bit.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg        <= '0;
      cnt          <= '0;
      ws_q         <= 1'b0;
      armed        <= 1'b0;
      commit_q     <= 1'b0;
      commit_right <= 1'b0;
      commit_word  <= '0;
    end else begin
      commit_q <= 1'b0;
      if (boundary_c) begin
        // Words ending before the first boundary are partial: never commit.
        commit_q     <= armed;
        commit_right <= ws_q;
        commit_word  <= word_c;
        armed        <= 1'b1;
        cnt          <= '0;
        shreg        <= '0;
        ws_q         <= ws_s2;
      end else if (bit_evt_c) begin
        shreg <= word_c;
        if (cnt_room_c) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pairing and output handshake
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      left_hold <= '0;
      left_held <= 1'b0;
      OUT_L     <= '0;
      OUT_R     <= '0;
      VALID     <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (commit_q && !commit_right) begin
        left_hold <= commit_word;
        left_held <= 1'b1;
      end

      // Left word is consumed whether the pair is loaded or dropped.
      if (pair_c) begin
        left_held <= 1'b0;
      end

      if (pair_load_c) begin
        OUT_L <= out_l_c;
        OUT_R <= out_r_c;
        VALID <= 1'b1;
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end

      if (pair_drop_c) begin
        OVERRUN <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx
// Directed bench for i2s_rx: drives an I2S stream at clk = 16x SCK, collects
// every accepted pair through a handshake monitor and compares against
// hand-computed expectations (stereo or mono depending on I2S_RX_MONO_EN).
// ---------------------------------------------------------------------------
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SCK, WS, SD, READY;
  logic [15:0] OUT_L, OUT_R;
  logic        VALID, OVERRUN;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] acc_q[$];

  i2s_rx #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SCK     (SCK),
    .WS      (WS),
    .SD      (SD),
    .READY   (READY),
    .OUT_L   (OUT_L),
    .OUT_R   (OUT_R),
    .VALID   (VALID),
    .OVERRUN (OVERRUN)
  );

  always #5 clk = ~clk;

  // Record each pair accepted at the coming posedge (inputs change at negedge).
  always @(negedge clk) begin
    #1;
    if (rst_n && VALID && READY) acc_q.push_back({OUT_L, OUT_R});
  end

  typedef struct {
    int unsigned n;
    logic [31:0] l;
    logic [31:0] r;
    logic [15:0] el;
    logic [15:0] er;
    logic [15:0] em;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [15:0] l, input logic [15:0] r,
                                       input logic [15:0] m);
`ifdef I2S_RX_MONO_EN
    return {m, m};
`else
    return {l, r};
`endif
  endfunction

  // One SCK period: 8 clk low (WS/SD change here), 8 clk high.
  // With lat set, VALID must be low after the 3rd posedge seeing SCK high
  // and high after the 4th.
  task automatic slot(input logic ws, input logic sd, input bit lat);
    @(negedge clk);
    SCK = 1'b0;
    WS  = ws;
    SD  = sd;
    repeat (7) @(negedge clk);
    @(negedge clk);
    SCK = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (lat && k == 3) chk("latency_p3_valid", 32'(VALID), 32'd0);
      if (lat && k == 4) chk("latency_p4_valid", 32'(VALID), 32'd1);
    end
  endtask

  // MSB..bit1 under ws, then the LSB in the slot where WS has flipped.
  task automatic send_word(input logic ws, input logic [31:0] w, input int unsigned n,
                           input bit lat);
    for (int i = int'(n) - 1; i >= 1; i--) slot(ws, w[i], 1'b0);
    slot(~ws, w[0], lat);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int unsigned n, input bit lat);
    send_word(1'b0, l, n, 1'b0);
    send_word(1'b1, r, n, lat);
  endtask

  task automatic pop_chk(input string name, input logic [31:0] exp);
    logic [31:0] got;
    chk({name, "_count"}, 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) got = acc_q.pop_front();
    else got = 'x;
    chk(name, got, exp);
    acc_q.delete();
  endtask

  initial begin
    vecs[0] = '{16, 32'h0001,   32'h FFFF,  16'h0001, 16'hFFFF, 16'h0000};
    vecs[1] = '{16, 32'h7FFF,   32'h8000,   16'h7FFF, 16'h8000, 16'hFFFF};
    vecs[2] = '{16, 32'h0000,   32'h0000,   16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{24, 32'h123456, 32'hFEDCBA, 16'h1234, 16'hFEDC, 16'h0888};
    vecs[4] = '{8,  32'h5A,     32'hC3,     16'h5A00, 16'hC300, 16'h0E80};
    vecs[5] = '{16, 32'h7FFF,   32'h7FFF,   16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[6] = '{16, 32'h8000,   32'h7FFF,   16'h8000, 16'h7FFF, 16'hFFFF};
    vecs[7] = '{16, 32'h0003,   32'h0000,   16'h0003, 16'h0000, 16'h0001};

    rst_n = 1'b0;
    SCK   = 1'b0;
    WS    = 1'b0;
    SD    = 1'b0;
    READY = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_out_l",   32'(OUT_L),   32'd0);
    chk("reset_out_r",   32'(OUT_R),   32'd0);
    chk("reset_valid",   32'(VALID),   32'd0);
    chk("reset_overrun", 32'(OVERRUN), 32'd0);

    // First frame only arms the receiver; its words are discarded.
    send_frame(32'h0, 32'h0, 16, 1'b0);
    chk("first_frame_dropped", 32'(VALID), 32'd0);
    send_frame(32'h1234, 32'hABCD, 16, 1'b1);
    chk("first_pair", {OUT_L, OUT_R}, pick(16'h1234, 16'hABCD, 16'hDF00));
    chk("first_valid", 32'(VALID), 32'd1);
    chk("first_overrun", 32'(OVERRUN), 32'd0);

    @(negedge clk);
    READY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("first_ready_clears", 32'(VALID), 32'd0);
    pop_chk("first_accepted", pick(16'h1234, 16'hABCD, 16'hDF00));

    foreach (vecs[i]) begin
      send_frame(vecs[i].l, vecs[i].r, vecs[i].n, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      pop_chk($sformatf("vec%0d", i), pick(vecs[i].el, vecs[i].er, vecs[i].em));
    end
    chk("stream_overrun", 32'(OVERRUN), 32'd0);

    // Downstream stalls across two pairs: second pair is dropped.
    @(negedge clk);
    READY = 1'b0;
    send_frame(32'h1111, 32'h2222, 16, 1'b0);
    chk("stall_pair1", {OUT_L, OUT_R}, pick(16'h1111, 16'h2222, 16'h1999));
    chk("stall_overrun_pre", 32'(OVERRUN), 32'd0);
    send_frame(32'h3333, 32'h4444, 16, 1'b0);
    chk("stall_pair_held", {OUT_L, OUT_R}, pick(16'h1111, 16'h2222, 16'h1999));
    chk("stall_valid_held", 32'(VALID), 32'd1);
    chk("stall_overrun_set", 32'(OVERRUN), 32'd1);
    @(negedge clk);
    READY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_ready_clears", 32'(VALID), 32'd0);
    chk("stall_overrun_sticky", 32'(OVERRUN), 32'd1);
    pop_chk("stall_accepted", pick(16'h1111, 16'h2222, 16'h1999));

    // Reset pulse partway through a left word.
    for (int i = 15; i >= 8; i--) slot(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    SCK   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midreset_out_l",   32'(OUT_L),   32'd0);
    chk("midreset_out_r",   32'(OUT_R),   32'd0);
    chk("midreset_valid",   32'(VALID),   32'd0);
    chk("midreset_overrun", 32'(OVERRUN), 32'd0);
    send_word(1'b0, 32'h9999, 16, 1'b0);
    send_word(1'b1, 32'h7777, 16, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_no_pair", 32'(acc_q.size()), 32'd0);
    send_frame(32'h5555, 32'h6666, 16, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    pop_chk("midreset_next_pair", pick(16'h5555, 16'h6666, 16'h5DDD));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
